// File: rtl/mem_channel_arbiter_if.sv
// Two-channel request/response bus plus the shared memory port of mem_channel_arbiter.
// slave = arbiter view, master = accelerator/memory-model view.
interface mem_channel_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int SIZE_W = 4
);
  logic [1:0]          req_oe;
  logic [1:0]          req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [2*SIZE_W-1:0] req_size;
  logic [2*DATA_W-1:0] rsp_rdata;
  logic [1:0]          rsp_rdy;
  logic                mem_oe;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [SIZE_W-1:0]   mem_size;
  logic [DATA_W-1:0]   mem_rdata;
  logic                err_conflict;

  modport slave (
    input  req_oe, req_we, req_addr, req_wdata, req_size, mem_rdata,
    output rsp_rdata, rsp_rdy, mem_oe, mem_we, mem_addr, mem_wdata, mem_size, err_conflict
  );

  modport master (
    output req_oe, req_we, req_addr, req_wdata, req_size, mem_rdata,
    input  rsp_rdata, rsp_rdy, mem_oe, mem_we, mem_addr, mem_wdata, mem_size, err_conflict
  );
endinterface

// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter sharing one fixed-latency byte memory between two level-held channels.
// Read completes READ_LAT+2 cycles after grant, write WRITE_LAT+1; a losing channel simply stays pending.
module mem_channel_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int SIZE_W    = 4,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input logic                  clock,
  input logic                  reset,
  mem_channel_arbiter_if.slave bus
);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                gnt_q, gnt_d;
  logic                wr_q, wr_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_oe_q, mem_oe_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [SIZE_W-1:0]   mem_size_q, mem_size_d;
  logic [2*DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_rdy_q, rsp_rdy_d;
  logic                err_q, err_d;

  logic [1:0]          vld;
  logic                pick;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [SIZE_W-1:0]   sel_size;
  logic [DATA_W-1:0]   rd_masked;

  // Size counts bits; anything at or above DATA_W naturally yields all ones.
  function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] sz);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < DATA_W; i++) m[i] = (i < int'(sz));
    return m;
  endfunction

  always_comb begin
    vld       = bus.req_oe ^ bus.req_we;
    pick      = (vld == 2'b11) ? ptr_q : vld[1];
    sel_addr  = pick ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
    sel_wdata = pick ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
    sel_size  = pick ? bus.req_size[2*SIZE_W-1:SIZE_W]  : bus.req_size[SIZE_W-1:0];
    rd_masked = bus.mem_rdata & size_mask(size_q);

    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    wr_d        = wr_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    err_d       = err_q;
    mem_oe_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_size_d  = '0;
    rsp_rdy_d   = 2'b00;

    case (state_q)
      IDLE: begin
        err_d = err_q | (|(bus.req_oe & bus.req_we));
        if (|vld) begin
          gnt_d       = pick;
          wr_d        = bus.req_we[pick];
          size_d      = sel_size;
          mem_oe_d    = ~bus.req_we[pick];
          mem_we_d    = bus.req_we[pick];
          mem_addr_d  = sel_addr;
          mem_size_d  = sel_size;
          mem_wdata_d = bus.req_we[pick] ? (sel_wdata & size_mask(sel_size)) : '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (wr_q) begin
          // A single-cycle write completes straight out of ISSUE to hit the C+WRITE_LAT+1 slot.
          if (WRITE_LAT > 1) begin
            cnt_d   = CNT_W'(WRITE_LAT - 2);
            state_d = WAIT;
          end else begin
            rsp_rdy_d[gnt_q] = 1'b1;
            state_d          = DONE;
          end
        end else begin
          cnt_d   = CNT_W'(READ_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_rdy_d[gnt_q] = 1'b1;
          if (!wr_q) begin
            if (gnt_q) rsp_rdata_d[2*DATA_W-1:DATA_W] = rd_masked;
            else       rsp_rdata_d[DATA_W-1:0]        = rd_masked;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        ptr_d   = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      wr_q        <= 1'b0;
      size_q      <= '0;
      cnt_q       <= '0;
      mem_oe_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_rdy_q   <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      mem_oe_q    <= mem_oe_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_rdy_q   <= rsp_rdy_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_oe       = mem_oe_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_size     = mem_size_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_rdy      = rsp_rdy_q;
  assign bus.err_conflict = err_q;
endmodule

// File: doc/mem_channel_arbiter.md
Name: mem_channel_arbiter

Overview:
- Shares one single-port, fixed-latency byte memory between the two master channels (index 0 and 1) of a synthesized accelerator's memory interface.
- Per-channel requests are level-based. Each channel asserts oe or we and holds it until its own rdy pulse.
- Serializes requests with round-robin priority, drives the memory port, and routes read data and completion pulses back to the owning channel.
- Sits between the accelerator's Mout_* bus and the off-chip/bench memory model.

Parameters:
- ADDR_W, 7, address width per channel.
- DATA_W, 8, data width per channel.
- SIZE_W, 4, access-size field width per channel (size is in bits).
- READ_LAT, 2, cycles from the mem_oe issue cycle to valid mem_rdata (minimum 1).
- WRITE_LAT, 1, cycles from the mem_we issue cycle to write completion (minimum 1).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_oe  in  2  per-channel read request, held until the matching rsp_rdy.
- req_we  in  2  per-channel write request, held until the matching rsp_rdy.
- req_addr  in  2*ADDR_W  channel k address in bits [k*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  per-channel write data.
- req_size  in  2*SIZE_W  per-channel access size in bits.
- rsp_rdata  out  2*DATA_W  per-channel read data, registered.
- rsp_rdy  out  2  per-channel one-cycle completion pulse.
- mem_oe  out  1  memory read strobe, one-cycle pulse.
- mem_we  out  1  memory write strobe, one-cycle pulse.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data, masked.
- mem_size  out  SIZE_W  memory access size.
- mem_rdata  in  DATA_W  memory read data, valid READ_LAT cycles after mem_oe.
- err_conflict  out  1  sticky flag: some channel asserted oe and we together.

Behaviour:
- Reset (asynchronous on reset=0):
  - All outputs go to 0.
  - FSM goes to IDLE and the priority pointer goes to 0.
  - Latency counter is cleared and any in-flight read is discarded; no rsp_rdy is produced for it.
  - err_conflict is cleared only by reset.
- Valid request: channel k is valid when exactly one of req_oe[k] and req_we[k] is high.
  - If both are high, set err_conflict and treat the channel as not requesting for that cycle.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If no channel is valid, stay in IDLE.
  - If one channel is valid, grant it.
  - If both are valid, grant the channel equal to the pointer.
  - On grant, register the channel, op, address, size and wdata, then go to ISSUE.
- ISSUE:
  - Drive mem_addr and mem_size for exactly one cycle, with mem_oe=1 (read) or mem_we=1 (write).
  - Drive mem_wdata = wdata & mask for a write.
  - Load the latency counter, then go to WAIT.
  - mem_* outputs are 0 in every other state.
- WAIT, read:
  - Count READ_LAT cycles from ISSUE.
  - In the cycle mem_rdata is valid, capture mem_rdata & mask into the granted channel's rsp_rdata.
  - Pulse rsp_rdy[grant] on the following cycle, then go to DONE.
- WAIT, write: pulse rsp_rdy[grant] WRITE_LAT cycles after ISSUE, then go to DONE.
- Mask: mask = (1<<size)-1; all ones when size >= DATA_W. size=0 yields mask 0.
- DONE:
  - One turnaround cycle with no sampling of the granted channel, so the requester can drop its request.
  - Set the pointer to the other channel, then go to IDLE.
- Latency from a request first seen in IDLE at cycle C:
  - Read: rsp_rdy at C+READ_LAT+2.
  - Write: rsp_rdy at C+WRITE_LAT+1.
  - Next grant is possible at C+READ_LAT+3 (read) or C+WRITE_LAT+2 (write).
- Response registers:
  - rsp_rdy is exactly one cycle wide and only for the granted channel; never both bits at once.
  - rsp_rdata[k] holds its value until the next read completion on channel k.
- Request dropped or changed after grant: ignored. The captured transaction completes and rsp_rdy still pulses.
- Non-granted channel's request: held pending and unaffected; it wins the next arbitration by round-robin.
- Address passes through unchanged; no range checking.

Test Plan:
- Reset, then ch0 read of addr 0x05 with size 8, memory returning 0xA5 (READ_LAT=2) -> mem_oe pulses at C+1 with mem_addr=0x05; rsp_rdata[7:0]=0xA5 and rsp_rdy=2'b01 at C+4; rsp_rdy[1] stays 0.
- ch1 write of addr 0x10, wdata 0xFF, size 4 -> mem_we pulses at C+1 with mem_wdata=0x0F and mem_size=4; rsp_rdy=2'b10 at C+2.
- ch0 and ch1 reads asserted together and held -> ch0 served first (pointer 0), then ch1; mem_oe never overlaps; the pointer alternates on a second simultaneous pair.
- ch0 asserts oe and we together while ch1 requests a read -> err_conflict=1 and stays 1; ch1 is served; ch0 never gets rsp_rdy.
- reset driven low during WAIT of a read -> all outputs 0 immediately; no rsp_rdy after release; a fresh read then completes normally.
- ch0 read requested with size 0 -> rsp_rdata[7:0]=0x00 and rsp_rdy pulses normally.
